// File: rtl/arb_perm_net.sv
// Two-stage deflection-routed 2x2 arbiter network with golden-ID priority.
// Each flit routes to the out port numbered by its dir bits, or is deflected
// if it loses an arbitration. Latency is two cycles and the network never stalls.

// One 2x2 arbiter node: steers the two input flits onto o0/o1 by one dir bit.
module arb_perm_node #(
    parameter int unsigned FLIT_W = 16,
    parameter int unsigned DIR_W  = 2,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned SEL    = 14
) (
    input  logic [FLIT_W-1:0] a,
    input  logic [FLIT_W-1:0] b,
    input  logic [ID_W-1:0]   golden_id,
    input  logic              rr,
    output logic [FLIT_W-1:0] o0_c,
    output logic [FLIT_W-1:0] o1_c,
    output logic              defl_c,
    output logic              tie_c
);

    localparam int unsigned ID_HI = FLIT_W - 2 - DIR_W;

    logic va;
    logic vb;
    logic ga;
    logic gb;
    logic da;
    logic db;
    logic b_wins;

    assign va = a[FLIT_W-1];
    assign vb = b[FLIT_W-1];
    assign ga = (a[ID_HI -: ID_W] == golden_id);
    assign gb = (b[ID_HI -: ID_W] == golden_id);
    assign da = a[SEL];
    assign db = b[SEL];

    // Priority: valid, then golden, then round-robin; the loser takes the other port.
    always_comb begin
        o0_c   = a;
        o1_c   = b;
        defl_c = 1'b0;
        tie_c  = 1'b0;
        b_wins = 1'b0;
        if (va && vb) begin
            if (ga != gb) begin
                b_wins = gb;
            end else begin
                b_wins = rr;
                tie_c  = 1'b1;
            end
            // Loser is deflected exactly when both want the same port.
            defl_c = (da == db);
            if (b_wins) begin
                if (db) begin
                    o0_c = a;
                    o1_c = b;
                end else begin
                    o0_c = b;
                    o1_c = a;
                end
            end else begin
                if (da) begin
                    o0_c = b;
                    o1_c = a;
                end else begin
                    o0_c = a;
                    o1_c = b;
                end
            end
        end else if (va) begin
            if (da) begin
                o0_c = b;
                o1_c = a;
            end
        end else if (vb) begin
            if (!db) begin
                o0_c = b;
                o1_c = a;
            end
        end
    end

endmodule

module arb_perm_net #(
    parameter int unsigned FLIT_W = 16,
    parameter int unsigned DIR_W  = 2,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned EPOCH  = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] in0,
    input  logic [FLIT_W-1:0] in1,
    input  logic [FLIT_W-1:0] in2,
    input  logic [FLIT_W-1:0] in3,
    input  logic              cnt_clr,
    output logic [FLIT_W-1:0] out0,
    output logic [FLIT_W-1:0] out1,
    output logic [FLIT_W-1:0] out2,
    output logic [FLIT_W-1:0] out3,
    output logic [ID_W-1:0]   golden_id,
    output logic [CNT_W-1:0]  defl_cnt
);

    localparam int unsigned EP_W  = (EPOCH > 1) ? $clog2(EPOCH) : 1;
    localparam int unsigned ACC_W = ((CNT_W > 3) ? CNT_W : 3) + 1;
    localparam int unsigned SEL1  = FLIT_W - 2;
    localparam int unsigned SEL2  = FLIT_W - 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [EP_W-1:0]  EP_LAST = EP_W'(EPOCH - 1);

    logic [FLIT_W-1:0] s1a_o0;
    logic [FLIT_W-1:0] s1a_o1;
    logic [FLIT_W-1:0] s1b_o0;
    logic [FLIT_W-1:0] s1b_o1;
    logic [3:0]        rr;
    logic [EP_W-1:0]   ep;

    logic [FLIT_W-1:0] n1a_o0_c;
    logic [FLIT_W-1:0] n1a_o1_c;
    logic [FLIT_W-1:0] n1b_o0_c;
    logic [FLIT_W-1:0] n1b_o1_c;
    logic [FLIT_W-1:0] n2a_o0_c;
    logic [FLIT_W-1:0] n2a_o1_c;
    logic [FLIT_W-1:0] n2b_o0_c;
    logic [FLIT_W-1:0] n2b_o1_c;
    logic [3:0]        defl_c;
    logic [3:0]        tie_c;
    logic [2:0]        defl_sum_c;
    logic [ACC_W-1:0]  acc_c;
    logic [CNT_W-1:0]  defl_nxt_c;

    arb_perm_node #(.FLIT_W(FLIT_W), .DIR_W(DIR_W), .ID_W(ID_W), .SEL(SEL1)) u_s1a (
        .a(in0), .b(in1), .golden_id(golden_id), .rr(rr[0]),
        .o0_c(n1a_o0_c), .o1_c(n1a_o1_c), .defl_c(defl_c[0]), .tie_c(tie_c[0])
    );

    arb_perm_node #(.FLIT_W(FLIT_W), .DIR_W(DIR_W), .ID_W(ID_W), .SEL(SEL1)) u_s1b (
        .a(in2), .b(in3), .golden_id(golden_id), .rr(rr[1]),
        .o0_c(n1b_o0_c), .o1_c(n1b_o1_c), .defl_c(defl_c[1]), .tie_c(tie_c[1])
    );

    arb_perm_node #(.FLIT_W(FLIT_W), .DIR_W(DIR_W), .ID_W(ID_W), .SEL(SEL2)) u_s2a (
        .a(s1a_o0), .b(s1b_o0), .golden_id(golden_id), .rr(rr[2]),
        .o0_c(n2a_o0_c), .o1_c(n2a_o1_c), .defl_c(defl_c[2]), .tie_c(tie_c[2])
    );

    arb_perm_node #(.FLIT_W(FLIT_W), .DIR_W(DIR_W), .ID_W(ID_W), .SEL(SEL2)) u_s2b (
        .a(s1a_o1), .b(s1b_o1), .golden_id(golden_id), .rr(rr[3]),
        .o0_c(n2b_o0_c), .o1_c(n2b_o1_c), .defl_c(defl_c[3]), .tie_c(tie_c[3])
    );

    // Per-cycle deflection total folded into the saturating counter.
    always_comb begin
        defl_sum_c = 3'(defl_c[0]) + 3'(defl_c[1]) + 3'(defl_c[2]) + 3'(defl_c[3]);
        acc_c      = ACC_W'(defl_cnt) + ACC_W'(defl_sum_c);
        defl_nxt_c = (acc_c > ACC_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(acc_c);
    end

    // Stage 1 and stage 2 flit registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1a_o0 <= '0;
            s1a_o1 <= '0;
            s1b_o0 <= '0;
            s1b_o1 <= '0;
            out0   <= '0;
            out1   <= '0;
            out2   <= '0;
            out3   <= '0;
        end else begin
            s1a_o0 <= n1a_o0_c;
            s1a_o1 <= n1a_o1_c;
            s1b_o0 <= n1b_o0_c;
            s1b_o1 <= n1b_o1_c;
            out0   <= n2a_o0_c;
            out1   <= n2a_o1_c;
            out2   <= n2b_o0_c;
            out3   <= n2b_o1_c;
        end
    end

    // Round-robin bits flip only on genuine ties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr <= '0;
        end else begin
            rr <= rr ^ tie_c;
        end
    end

    // Epoch counter advances the golden ID once per EPOCH cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ep        <= '0;
            golden_id <= '0;
        end else if (ep == EP_LAST) begin
            ep        <= '0;
            golden_id <= golden_id + ID_W'(1);
        end else begin
            ep        <= ep + EP_W'(1);
        end
    end

    // Deflection counter; clear wins over this cycle's deflections.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            defl_cnt <= '0;
        end else begin
            defl_cnt <= defl_nxt_c;
        end
    end

endmodule

// File: tb/tb_arb_perm_net.sv
// Scoreboard bench for arb_perm_net: default instance for routing checks,
// small instance (ID_W=2, EPOCH=4, CNT_W=3) for epoch and saturation checks.
module tb_arb_perm_net;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic        cnt_clr = 1'b0;
    logic [15:0] out0, out1, out2, out3;
    logic [3:0]  golden_a;
    logic [15:0] defl_a;

    logic [15:0] b_in0 = '0, b_in1 = '0, b_in2 = '0, b_in3 = '0;
    logic        b_clr = 1'b0;
    logic [15:0] bo0, bo1, bo2, bo3;
    logic [1:0]  golden_b;
    logic [2:0]  defl_b;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_q [4][$];
    logic [15:0] oa [4];

    assign oa[0] = out0;
    assign oa[1] = out1;
    assign oa[2] = out2;
    assign oa[3] = out3;

    always #5 clk = ~clk;

    arb_perm_net u_dut (
        .clk(clk), .rst_n(rst_n),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .cnt_clr(cnt_clr),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .golden_id(golden_a), .defl_cnt(defl_a)
    );

    arb_perm_net #(.FLIT_W(16), .DIR_W(2), .ID_W(2), .EPOCH(4), .CNT_W(3)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in0(b_in0), .in1(b_in1), .in2(b_in2), .in3(b_in3),
        .cnt_clr(b_clr),
        .out0(bo0), .out1(bo1), .out2(bo2), .out3(bo3),
        .golden_id(golden_b), .defl_cnt(defl_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Default-layout flit: valid, dir[1:0], id[3:0], payload[8:0].
    function automatic logic [15:0] mk(input int d, input int id, input int pay);
        return {1'b1, 2'(d), 4'(id), 9'(pay)};
    endfunction

    // Small-instance flit: valid, dir[1:0], id[1:0], payload[10:0].
    function automatic logic [15:0] mkb(input int d, input int id, input int pay);
        return {1'b1, 2'(d), 2'(id), 11'(pay)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_in();
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    endtask

    // Monitor: every valid output must match the next expected flit for that port.
    always @(negedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (oa[p][15] === 1'b1) begin
                if (exp_q[p].size() == 0) begin
                    chk($sformatf("out%0d_unexpected", p), 32'(oa[p]), 32'h0);
                end else begin
                    chk($sformatf("out%0d_flit", p), 32'(oa[p]), 32'(exp_q[p].pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] f0, f1, f2, f3;

        // Reset state
        do_reset();
        chk("rst_out0", 32'(out0), 32'h0);
        chk("rst_out3", 32'(out3), 32'h0);
        chk("rst_golden", 32'(golden_a), 32'h0);
        chk("rst_defl", 32'(defl_a), 32'h0);

        // Epoch wrap on the small instance
        chk("ep_0", 32'(golden_b), 32'h0);
        step(3);
        chk("ep_3", 32'(golden_b), 32'h0);
        step(1);
        chk("ep_4", 32'(golden_b), 32'h1);
        step(11);
        chk("ep_15", 32'(golden_b), 32'h3);
        step(1);
        chk("ep_16", 32'(golden_b), 32'h0);

        // Single flit in0 dir=11 -> out3
        do_reset();
        in0 = mk(3, 1, 9'h0AA);
        exp_q[3].push_back(mk(3, 1, 9'h0AA));
        step(1);
        clear_in();
        step(3);
        chk("single_defl", 32'(defl_a), 32'h0);

        // Conflict-free permutation of four flits
        do_reset();
        f0 = mk(0, 1, 9'h101); f1 = mk(2, 2, 9'h102);
        f2 = mk(1, 3, 9'h103); f3 = mk(3, 4, 9'h104);
        in0 = f0; in1 = f1; in2 = f2; in3 = f3;
        exp_q[0].push_back(f0); exp_q[2].push_back(f1);
        exp_q[1].push_back(f2); exp_q[3].push_back(f3);
        step(1);
        clear_in();
        step(3);
        chk("perm_defl", 32'(defl_a), 32'h0);

        // Round-robin conflict: in0 wins first, in1 wins second
        do_reset();
        f0 = mk(0, 1, 9'h011); f1 = mk(0, 2, 9'h012);
        in0 = f0; in1 = f1;
        exp_q[0].push_back(f0); exp_q[2].push_back(f1);
        step(1);
        chk("rr_defl_1", 32'(defl_a), 32'h1);
        f2 = mk(0, 3, 9'h013); f3 = mk(0, 4, 9'h014);
        in0 = f2; in1 = f3;
        exp_q[0].push_back(f3); exp_q[2].push_back(f2);
        step(1);
        chk("rr_defl_2", 32'(defl_a), 32'h2);
        clear_in();
        step(3);
        chk("rr_defl_end", 32'(defl_a), 32'h2);

        // Golden priority: in1 (id 0) beats in0; rr must stay at 0
        do_reset();
        chk("gold_id", 32'(golden_a), 32'h0);
        f0 = mk(0, 5, 9'h1A5); f1 = mk(0, 0, 9'h1B0);
        in0 = f0; in1 = f1;
        exp_q[0].push_back(f1); exp_q[2].push_back(f0);
        step(1);
        f2 = mk(0, 6, 9'h1C6); f3 = mk(0, 7, 9'h1D7);
        in0 = f2; in1 = f3;
        exp_q[0].push_back(f2); exp_q[2].push_back(f3);
        step(1);
        clear_in();
        step(3);
        chk("gold_defl", 32'(defl_a), 32'h2);

        // Mid-run reset with four flits in stage 1
        in0 = mk(0, 1, 9'h0E1); in1 = mk(2, 2, 9'h0E2);
        in2 = mk(1, 3, 9'h0E3); in3 = mk(3, 4, 9'h0E4);
        step(1);
        rst_n = 1'b0;
        clear_in();
        step(1);
        chk("mid_out0", 32'(out0), 32'h0);
        chk("mid_out1", 32'(out1), 32'h0);
        chk("mid_out2", 32'(out2), 32'h0);
        chk("mid_out3", 32'(out3), 32'h0);
        chk("mid_golden", 32'(golden_a), 32'h0);
        chk("mid_defl", 32'(defl_a), 32'h0);
        rst_n = 1'b1;
        step(2);
        chk("mid_post_valid", 32'({out0[15], out1[15], out2[15], out3[15]}), 32'h0);
        step(1);

        // Saturation and clear on the small instance: one deflection per cycle
        do_reset();
        b_in0 = mkb(0, 1, 11'h055); b_in1 = mkb(0, 2, 11'h066);
        step(6);
        chk("sat_6", 32'(defl_b), 32'h6);
        step(1);
        chk("sat_7", 32'(defl_b), 32'h7);
        step(5);
        chk("sat_hold", 32'(defl_b), 32'h7);
        b_clr = 1'b1;
        step(1);
        chk("sat_clr", 32'(defl_b), 32'h0);
        b_clr = 1'b0;
        step(1);
        chk("sat_resume", 32'(defl_b), 32'h1);
        b_in0 = '0; b_in1 = '0;
        step(3);

        for (int p = 0; p < 4; p++) begin
            chk($sformatf("q%0d_drained", p), 32'(exp_q[p].size()), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
